// File: rtl/candle_slew.sv
// Slew-rate limiter between the flicker brightness generator and the PWM stage.
// Walks an internal level toward an accepted target and republishes it only at PWM period ends.
module candle_slew #(
  parameter int WIDTH      = 8,
  parameter int MAX_STEP   = 16,
  parameter int HOLD_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             period_end,
  input  logic             target_valid,
  input  logic [WIDTH-1:0] target,
  output logic             target_ready,
  output logic [WIDTH-1:0] level,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int             CW     = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [WIDTH-1:0] STEP   = WIDTH'(MAX_STEP);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(MAX_STEP);
  localparam logic [CW-1:0]    HOLD   = CW'(HOLD_TICKS);

  state_t            state, state_n;
  logic [WIDTH-1:0]  cur, cur_n;
  logic [WIDTH-1:0]  tgt, tgt_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic signed [WIDTH:0] diff;
  logic [WIDTH:0]    mag;

  // Handshake: a target transfers on the rising edge where target_valid && target_ready;
  // target_ready is high only in IDLE, and upstream holds target stable until it transfers.
  assign target_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign fsm_state    = state;

  // One extra bit keeps the distance signed, so stepping by MAX_STEP can never wrap.
  always_comb begin
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    tgt_n   = tgt;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (target_valid) begin
          tgt_n   = target;
          cnt_n   = '0;
          state_n = (target == cur) ? SETTLE : RAMP;
        end
      end
      RAMP: begin
        if (tick) begin
          if (mag <= STEP_W) begin
            cur_n   = tgt;
            cnt_n   = '0;
            state_n = SETTLE;
          end else if (diff[WIDTH]) begin
            cur_n = cur - STEP;
          end else begin
            cur_n = cur + STEP;
          end
        end
      end
      SETTLE: begin
        if (HOLD_TICKS == 0) begin
          state_n = IDLE;
        end else if (tick) begin
          cnt_n = cnt + CW'(1);
          if (cnt_n == HOLD) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // level samples the pre-step cur, so a coincident tick shows up one period later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cur   <= '0;
      tgt   <= '0;
      cnt   <= '0;
      level <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      tgt   <= tgt_n;
      cnt   <= cnt_n;
      if (period_end) level <= cur;
    end
  end

endmodule

// File: tb/tb_candle_slew.sv
// Directed bench for candle_slew: vector tables for ramps and dwell,
// hand-written sequences for period alignment, back-pressure and mid-ramp reset.
module tb_candle_slew;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, period_end, target_valid;
  logic [7:0] target;
  logic       target_ready, busy;
  logic [7:0] level;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  candle_slew #(.WIDTH(8), .MAX_STEP(16), .HOLD_TICKS(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .period_end(period_end),
    .target_valid(target_valid), .target(target), .target_ready(target_ready),
    .level(level), .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       tk, pe, tv;
    logic [7:0] tg;
    logic [7:0] lvl;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic tk, input logic pe, input logic tv,
                              input logic [7:0] tg, input logic [7:0] lvl, input logic [1:0] st);
    vec_t v;
    v.tk = tk; v.pe = pe; v.tv = tv; v.tg = tg; v.lvl = lvl; v.st = st;
    vecs.push_back(v);
  endfunction

  function automatic void add_accept(input logic [7:0] tg, input logic [7:0] lvl,
                                     input logic tk, input logic [1:0] st);
    add(tk, 1'b1, 1'b1, tg, lvl, st);
  endfunction

  function automatic void add_step(input logic [7:0] p, input logic [7:0] v, input logic last);
    add(1'b1, 1'b1, 1'b0, 8'd0, p, last ? 2'd2 : 2'd1);
    add(1'b0, 1'b1, 1'b0, 8'd0, v, last ? 2'd2 : 2'd1);
  endfunction

  function automatic void add_dwell(input logic [7:0] v);
    for (int k = 1; k <= 4; k++) begin
      add(1'b1, 1'b1, 1'b0, 8'd0, v, (k == 4) ? 2'd0 : 2'd2);
      add(1'b0, 1'b1, 1'b0, 8'd0, v, (k == 4) ? 2'd0 : 2'd2);
    end
  endfunction

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      tick = vecs[i].tk; period_end = vecs[i].pe;
      target_valid = vecs[i].tv; target = vecs[i].tg;
      step();
      check($sformatf("%s[%0d].level", tag, i), level, vecs[i].lvl);
      check($sformatf("%s[%0d].state", tag, i), fsm_state, vecs[i].st);
      check($sformatf("%s[%0d].ready", tag, i), target_ready, vecs[i].st == 2'd0);
      check($sformatf("%s[%0d].busy", tag, i), busy, vecs[i].st != 2'd0);
    end
    vecs.delete();
    tick = 0; period_end = 0; target_valid = 0; target = 0;
  endtask

  initial begin
    int          k, n;
    logic [7:0]  exp_cur, exp_lvl;
    logic        accepted;

    // 1. Reset with inputs toggling, then 100 idle ticks
    rst = 0; tick = 0; period_end = 0; target_valid = 0; target = 0;
    for (int i = 0; i < 6; i++) begin
      tick = 1'($urandom_range(0, 1)); period_end = 1'($urandom_range(0, 1));
      target_valid = 1'($urandom_range(0, 1)); target = 8'($urandom_range(0, 255));
      step();
      check("rst.level", level, 0);
      check("rst.ready", target_ready, 1);
      check("rst.busy", busy, 0);
    end
    target_valid = 0;
    rst = 1;
    for (int i = 0; i < 200; i++) begin
      tick = (i % 2 == 1); period_end = 1'($urandom_range(0, 1));
      target = 8'($urandom_range(0, 255));
      step();
      if (i % 20 == 0) begin
        check("idle.level", level, 0);
        check("idle.ready", target_ready, 1);
      end
    end
    tick = 0; period_end = 0;

    // 2. Upward ramp 0 -> 100; tick at acceptance must not step
    add_accept(8'd100, 8'd0, 1'b1, 2'd1);
    add_step(0, 16, 0);  add_step(16, 32, 0); add_step(32, 48, 0);
    add_step(48, 64, 0); add_step(64, 80, 0); add_step(80, 96, 0);
    add_step(96, 100, 1);
    add_dwell(100);
    run_table("up");

    // 3. Downward ramps 100 -> 10, 10 -> 5, 5 -> 0
    add_accept(8'd10, 8'd100, 1'b0, 2'd1);
    add_step(100, 84, 0); add_step(84, 68, 0); add_step(68, 52, 0);
    add_step(52, 36, 0);  add_step(36, 20, 0); add_step(20, 10, 1);
    add_dwell(10);
    add_accept(8'd5, 8'd10, 1'b0, 2'd1);
    add_step(10, 5, 1);
    add_dwell(5);
    add_accept(8'd0, 8'd5, 1'b0, 2'd1);
    add_step(5, 0, 1);
    add_dwell(0);
    run_table("down");

    // 4. Period alignment: ticks every 7 cycles, period_end every 50 (phase 42)
    target_valid = 1; target = 8'd200;
    step();
    target_valid = 0;
    k = 0; exp_cur = 0; exp_lvl = 0;
    for (int c = 1; c <= 125; c++) begin
      tick = (c % 7 == 0); period_end = (c % 50 == 42);
      if (period_end) exp_lvl = exp_cur;
      if (tick) begin
        k++;
        if (k < 13) exp_cur = 8'(16 * k);
        else exp_cur = 8'd200;
      end
      step();
      check($sformatf("align.level@%0d", c), level, exp_lvl);
      if (c == 42) check("align.coincident", level, 80);
    end
    tick = 0; period_end = 0;
    check("align.ready", target_ready, 1);
    check("align.final", level, 200);

    // 5. Back-pressure: 200 held while ramping to 168, then accepted
    target_valid = 1; target = 8'd168; period_end = 1;
    step();
    target = 8'd200;
    accepted = 0; n = 0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      if (target_ready) begin
        tick = 0;
        step();
        accepted = 1;
      end else begin
        check("bp.busy", busy, 1);
        tick = (i % 2 == 1);
        step();
        if (tick) n++;
      end
    end
    target_valid = 0; tick = 0;
    check("bp.accepted", accepted, 1);
    check("bp.ticks_before_accept", n, 6);
    check("bp.level_at_accept", level, 168);
    check("bp.state_after_accept", fsm_state, 1);
    add_step(168, 184, 0); add_step(184, 200, 1);
    add_dwell(200);
    // equal target goes straight to SETTLE
    add_accept(8'd200, 8'd200, 1'b0, 2'd2);
    add_dwell(200);
    run_table("bp");

    // 6. Reset mid-RAMP between clock edges
    add_accept(8'd100, 8'd200, 1'b0, 2'd1);
    add_step(200, 184, 0);
    run_table("prerst");
    tick = 1; period_end = 1;
    #2;
    rst = 0;
    #1;
    check("rst_mid.level", level, 0);
    check("rst_mid.ready", target_ready, 1);
    check("rst_mid.busy", busy, 0);
    tick = 0; period_end = 0;
    step();
    #2;
    rst = 1;
    step();
    check("rst_rel.ready", target_ready, 1);
    check("rst_rel.level", level, 0);
    add_accept(8'd40, 8'd0, 1'b0, 2'd1);
    add_step(0, 16, 0); add_step(16, 32, 0); add_step(32, 40, 1);
    add_dwell(40);
    run_table("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/candle_slew.md
# candle_slew

Slew-rate limiter and period-aligned brightness register between the flicker brightness generator and the PWM stage of the candle design. Accepts a new target brightness through a valid/ready handshake. Walks an internal level toward the target by at most MAX_STEP per flicker tick. Presents the result to the PWM `value` input, updating it only at PWM period boundaries so no PWM period ever sees a mid-period duty change.

## Interface

Parameters:
- `WIDTH`, 8, brightness width in bits.
- `MAX_STEP`, 16, largest change of the internal level per tick (1..2^WIDTH-1).
- `HOLD_TICKS`, 4, ticks to dwell at a reached target before a new target is accepted (0 = no dwell).

Ports:
- `clk`, in, 1, single system clock, all state on rising edge.
- `rst`, in, 1, asynchronous, active-low reset; clears all state immediately when low.
- `tick`, in, 1, one-cycle step strobe at the flicker rate (driven by `flkr_en`).
- `period_end`, in, 1, one-cycle strobe from PWM marking the last cycle of a PWM period.
- `target_valid`, in, 1, upstream presents a new target.
- `target`, in, WIDTH, requested brightness; must be held stable while `target_valid` is high and `target_ready` is low.
- `target_ready`, out, 1, block can accept a target (high only in IDLE).
- `level`, out, WIDTH, registered brightness to PWM `value`.
- `busy`, out, 1, high in RAMP or SETTLE.

## Operation

- Registers: `cur` (WIDTH), `tgt` (WIDTH), `level` (WIDTH), settle counter (wide enough for HOLD_TICKS), 2-bit state.
- States: IDLE, RAMP, SETTLE.
- `target_ready` is combinational: `state == IDLE`. `busy` is `state != IDLE`.
- IDLE, with `target_valid`: the handshake fires. `tgt <= target`.
  - If `target == cur`: go to SETTLE with the counter cleared.
  - Otherwise go to RAMP.
- RAMP, on `tick`:
  - Compute `diff = tgt - cur` in WIDTH+1 signed bits.
  - If `|diff| <= MAX_STEP`: `cur <= tgt`, go to SETTLE with the counter cleared.
  - Otherwise `cur <= cur ± MAX_STEP`, with the sign following `diff`.
  - `cur` never leaves the range 0..2^WIDTH-1; there is no wrap-around.
- SETTLE, on `tick`: increment the counter. When the counter reaches HOLD_TICKS, go to IDLE.
  - HOLD_TICKS = 0: SETTLE exits to IDLE on the next clock, without waiting for a tick.
- `level`, in any state: `level <= cur` on `period_end`. `level` changes at no other time.
- `tick` in IDLE is ignored.
- `target_valid` outside IDLE is not accepted. Upstream holds the target until it is accepted. No target is ever dropped or overwritten.

## Timing

- Reset values (asynchronous, while `rst` = 0):
  - `cur` = 0, `tgt` = 0, `level` = 0, counter = 0.
  - state = IDLE, `target_ready` = 1, `busy` = 0.
- Handshake: accepted on the rising edge where `target_valid && target_ready`. `target_ready` is low from the following cycle.
- A `tick` in the same cycle as acceptance does not step. The first step occurs at the first `tick` strictly after acceptance.
- `cur` updates on the edge of a `tick` cycle.
- `level` reflects `cur` at the first `period_end` edge after that update.
- Worst-case latency from a `cur` change to `level` is one PWM period.
- `tick` and `period_end` in the same cycle: `level` loads the old `cur`, i.e. the value before this tick's step.
- Ramp length: ceil(|target - cur| / MAX_STEP) ticks.
- Next acceptance: HOLD_TICKS further ticks after the final step tick.
- Reset asserted mid-RAMP or mid-SETTLE: everything clears at once, and `level` drops to 0 asynchronously.
- After reset release the block is ready on the first clock.

## Test plan

1. Reset and idle:
   - Stimulus: assert `rst` = 0 with arbitrary inputs toggling.
   - Required: `level` = 0, `target_ready` = 1, `busy` = 0.
   - Stimulus: release reset, no `target_valid`, 100 ticks.
   - Required: no change.
2. Upward ramp (defaults):
   - Stimulus: `cur` = 0, accept target = 100, `period_end` every cycle.
   - Required: `cur` takes 16, 32, 48, 64, 80, 96, 100 on successive ticks. Then 4 dwell ticks, then `target_ready` = 1. `level` follows `cur` one cycle later.
3. Downward ramp:
   - Stimulus: from 100, accept target = 10.
   - Required: `cur` = 84, 68, 52, 36, 20, 10; `cur` never underflows.
   - Stimulus: from 5, accept target = 0.
   - Required: a single step to 0.
4. Period alignment:
   - Stimulus: `period_end` every 50 cycles, ticks every 7 cycles.
   - Required: `level` changes only on `period_end` edges. On a coincident `tick` + `period_end`, `level` gets the pre-step value.
5. Back-pressure and equal target:
   - Stimulus: hold `target_valid` with 200 during RAMP.
   - Required: not accepted until IDLE, then accepted and ramped.
   - Stimulus: target equal to `cur`.
   - Required: goes straight to SETTLE; `cur` unchanged.
6. Reset mid-operation:
   - Stimulus: assert `rst` low mid-RAMP, between clock edges.
   - Required: `level` = 0 immediately, IDLE after release, and the next target ramps from 0.
